// File: rtl/fpnew_divsqrt_th_ctrl_if.sv
// Handshake bundle between the issue/completion controller and its neighbours:
// upstream op channel, flush, divsqrt unit control and the completion channel.
interface fpnew_divsqrt_th_ctrl_if #(
  parameter int unsigned TagWidth = 8,
  parameter int unsigned AuxWidth = 1
);
  // upstream op channel
  logic                in_valid_i;
  logic                in_ready_o;
  logic [TagWidth-1:0] tag_i;
  logic [AuxWidth-1:0] aux_i;
  logic                flush_i;
  // divsqrt unit control / status
  logic                fsm_ready_i;
  logic                fsm_start_o;
  logic                fsm_kill_o;
  logic                unit_done_i;
  // completion channel
  logic                out_valid_o;
  logic                out_ready_i;
  logic [TagWidth-1:0] tag_o;
  logic [AuxWidth-1:0] aux_o;
  logic                busy_o;
  logic                timeout_o;

  // master: the surroundings (issue logic, divsqrt unit, consumer)
  modport master (
    output in_valid_i, tag_i, aux_i, flush_i, fsm_ready_i, unit_done_i, out_ready_i,
    input  in_ready_o, fsm_start_o, fsm_kill_o, out_valid_o, tag_o, aux_o, busy_o, timeout_o
  );

  // slave: the controller itself
  modport slave (
    input  in_valid_i, tag_i, aux_i, flush_i, fsm_ready_i, unit_done_i, out_ready_i,
    output in_ready_o, fsm_start_o, fsm_kill_o, out_valid_o, tag_o, aux_o, busy_o, timeout_o
  );
endinterface

// File: rtl/fpnew_divsqrt_th_ctrl.sv
// Issue/completion controller for the multi-cycle divsqrt datapath.
// One op in flight at a time; holds its tag/aux, forwards the unit's done pulse
// as a completion (with backpressure via HOLD) and kills runaway ops by watchdog.
// The bus interface must be instantiated with the same TagWidth/AuxWidth.
module fpnew_divsqrt_th_ctrl #(
  parameter int unsigned TagWidth      = 8,
  parameter int unsigned AuxWidth      = 1,
  parameter int unsigned TimeoutCycles = 128
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  fpnew_divsqrt_th_ctrl_if.slave bus
);

  // counter must be able to hold TimeoutCycles itself (saturation value)
  localparam int unsigned CntWidth = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [TagWidth-1:0] tag_reg;
  logic [AuxWidth-1:0] aux_reg;
  logic [CntWidth-1:0] cnt_reg;

  logic accept;
  logic in_ready;
  logic fsm_start;
  logic fsm_kill;
  logic out_valid;
  logic timeout;
  logic wd_fire;

  // watchdog compare; a zero timeout removes it entirely
  generate
    if (TimeoutCycles > 0) begin : g_wd
      assign wd_fire = (cnt_reg == CntWidth'(TimeoutCycles - 1));
    end else begin : g_no_wd
      assign wd_fire = 1'b0;
    end
  endgenerate

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // capture tag/aux of the accepted op; only written on accept
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_reg <= '0;
      aux_reg <= '0;
    end else if (accept) begin
      tag_reg <= bus.tag_i;
      aux_reg <= bus.aux_i;
    end
  end

  // cycles spent in BUSY, cleared on accept, saturating at TimeoutCycles
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
    end else if (state_reg == BUSY && cnt_reg != CntWidth'(TimeoutCycles)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // next-state and handshake outputs; priority flush > done > watchdog
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    accept     = 1'b0;
    fsm_start  = 1'b0;
    fsm_kill   = 1'b0;
    out_valid  = 1'b0;
    timeout    = 1'b0;
    if (!rst_i) begin
      case (state_reg)
        IDLE: begin
          in_ready  = bus.fsm_ready_i & ~bus.flush_i;
          accept    = bus.in_valid_i & in_ready;
          fsm_start = accept;
          if (accept) state_next = BUSY;
        end
        BUSY: begin
          if (bus.flush_i) begin
            // a done arriving together with the flush is dropped
            fsm_kill   = 1'b1;
            state_next = IDLE;
          end else if (bus.unit_done_i) begin
            // zero-latency bypass of the unit's result valid
            out_valid  = 1'b1;
            state_next = bus.out_ready_i ? IDLE : HOLD;
          end else if (wd_fire) begin
            fsm_kill   = 1'b1;
            timeout    = 1'b1;
            state_next = IDLE;
          end
        end
        HOLD: begin
          // unit is already idle here, so a flush needs no kill
          if (bus.flush_i) begin
            state_next = IDLE;
          end else begin
            out_valid = 1'b1;
            if (bus.out_ready_i) state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready;
  assign bus.fsm_start_o = fsm_start;
  assign bus.fsm_kill_o  = fsm_kill;
  assign bus.out_valid_o = out_valid;
  assign bus.timeout_o   = timeout;
  assign bus.busy_o      = ~rst_i & (state_reg != IDLE);
  // tag/aux read as zero when idle or in reset, otherwise the held values
  assign bus.tag_o       = (rst_i || state_reg == IDLE) ? '0 : tag_reg;
  assign bus.aux_o       = (rst_i || state_reg == IDLE) ? '0 : aux_reg;

  // protocol sanity
  a_done_in_flight : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.unit_done_i |-> (state_reg != IDLE));
  a_start_needs_ready : assert property (@(posedge clk_i) disable iff (rst_i)
    bus.fsm_start_o |-> bus.fsm_ready_i);
  a_start_kill_excl : assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.fsm_start_o && bus.fsm_kill_o));

endmodule

// File: tb/tb_fpnew_divsqrt_th_ctrl.sv
// Directed bench for the divsqrt issue/completion controller: default instance
// for handshake/flush/reset scenarios, a TimeoutCycles=4 instance for the watchdog.
module tb_fpnew_divsqrt_th_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  fpnew_divsqrt_th_ctrl_if #(.TagWidth(8), .AuxWidth(1)) bus ();
  fpnew_divsqrt_th_ctrl_if #(.TagWidth(8), .AuxWidth(1)) wbus ();

  fpnew_divsqrt_th_ctrl #(.TagWidth(8), .AuxWidth(1), .TimeoutCycles(128)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  fpnew_divsqrt_th_ctrl #(.TagWidth(8), .AuxWidth(1), .TimeoutCycles(4)) u_wd (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (wbus)
  );

  // compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge (inputs are driven here)
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // wait for the falling edge, where outputs are sampled
  task automatic settle();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.in_valid_i  = 0; bus.tag_i = '0; bus.aux_i = '0; bus.flush_i = 0;
    bus.fsm_ready_i = 1; bus.unit_done_i = 0; bus.out_ready_i = 0;
    wbus.in_valid_i = 0; wbus.tag_i = '0; wbus.aux_i = '0; wbus.flush_i = 0;
    wbus.fsm_ready_i = 1; wbus.unit_done_i = 0; wbus.out_ready_i = 0;
  endtask

  // accept an op on the default instance in the current cycle (cycle 0)
  task automatic accept_op(input logic [7:0] t, input logic a);
    bus.in_valid_i = 1; bus.tag_i = t; bus.aux_i = a; bus.fsm_ready_i = 1;
    settle();
    chk("acc_ready", bus.in_ready_o, 1);
    chk("acc_start", bus.fsm_start_o, 1);
    $display("accept tag=%02h", t);
    tick();
    bus.in_valid_i = 0; bus.tag_i = '0; bus.aux_i = '0;
  endtask

  initial begin
    clear_inputs();
    // reset: everything forced low even with a ready unit and a valid op
    rst = 1; bus.in_valid_i = 1;
    settle();
    chk("rst_in_ready", bus.in_ready_o, 0);
    chk("rst_start", bus.fsm_start_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_out_valid", bus.out_valid_o, 0);
    tick();
    tick();
    rst = 0; bus.in_valid_i = 0; bus.fsm_ready_i = 0;
    settle();
    chk("post_rst_in_ready", bus.in_ready_o, 0);
    chk("post_rst_tag", bus.tag_o, 0);
    chk("post_rst_busy", bus.busy_o, 0);
    tick();

    // basic: accept 5A at cyc0, done with out_ready at cyc12
    accept_op(8'h5A, 1'b1);           // now at cyc1
    settle();
    chk("basic_busy", bus.busy_o, 1);
    chk("basic_in_ready", bus.in_ready_o, 0);
    chk("basic_no_valid", bus.out_valid_o, 0);
    repeat (11) tick();               // cyc12
    bus.unit_done_i = 1; bus.out_ready_i = 1;
    settle();
    chk("basic_valid", bus.out_valid_o, 1);
    chk("basic_tag", bus.tag_o, 8'h5A);
    chk("basic_aux", bus.aux_o, 1);
    $display("complete tag=%02h", bus.tag_o);
    tick();                           // cyc13
    bus.unit_done_i = 0; bus.out_ready_i = 0;
    settle();
    chk("basic_idle_busy", bus.busy_o, 0);
    chk("basic_idle_valid", bus.out_valid_o, 0);
    chk("basic_idle_ready", bus.in_ready_o, 1);
    tick();

    // backpressure: done cyc12, out_ready low until cyc15
    accept_op(8'hC3, 1'b0);
    repeat (11) tick();               // cyc12
    bus.unit_done_i = 1; bus.out_ready_i = 0;
    settle();
    chk("bp_valid12", bus.out_valid_o, 1);
    chk("bp_tag12", bus.tag_o, 8'hC3);
    for (int c = 13; c <= 14; c++) begin
      tick();
      bus.unit_done_i = 0; bus.in_valid_i = 1; bus.tag_i = 8'hEE;
      settle();
      chk("bp_valid_hold", bus.out_valid_o, 1);
      chk("bp_tag_hold", bus.tag_o, 8'hC3);
      chk("bp_in_ready", bus.in_ready_o, 0);
      chk("bp_no_start", bus.fsm_start_o, 0);
      chk("bp_busy", bus.busy_o, 1);
    end
    tick();                           // cyc15
    bus.in_valid_i = 0; bus.out_ready_i = 1;
    settle();
    chk("bp_valid15", bus.out_valid_o, 1);
    chk("bp_ready15", bus.in_ready_o, 0);
    $display("complete tag=%02h after backpressure", bus.tag_o);
    tick();                           // cyc16
    bus.out_ready_i = 0;
    settle();
    chk("bp_valid16", bus.out_valid_o, 0);
    chk("bp_ready16", bus.in_ready_o, 1);
    tick();

    // unit busy: no accept until fsm_ready rises
    bus.fsm_ready_i = 0; bus.in_valid_i = 1; bus.tag_i = 8'h11;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("ub_in_ready", bus.in_ready_o, 0);
      chk("ub_no_start", bus.fsm_start_o, 0);
      tick();
    end
    accept_op(8'h11, 1'b0);           // ready rises: accept same cycle

    // flush in BUSY at cyc5
    repeat (4) tick();                // cyc5
    bus.flush_i = 1;
    settle();
    chk("fl_kill", bus.fsm_kill_o, 1);
    chk("fl_no_valid", bus.out_valid_o, 0);
    chk("fl_no_timeout", bus.timeout_o, 0);
    $display("flush in BUSY");
    tick();
    bus.flush_i = 0;
    settle();
    chk("fl_idle", bus.busy_o, 0);
    chk("fl_kill_off", bus.fsm_kill_o, 0);
    tick();

    // flush in IDLE blocks accept, no kill
    bus.flush_i = 1; bus.in_valid_i = 1; bus.tag_i = 8'h99;
    settle();
    chk("fli_ready", bus.in_ready_o, 0);
    chk("fli_start", bus.fsm_start_o, 0);
    chk("fli_kill", bus.fsm_kill_o, 0);
    tick();
    bus.flush_i = 0; bus.in_valid_i = 0;

    // flush together with done: completion dropped
    accept_op(8'h22, 1'b1);
    repeat (2) tick();
    bus.flush_i = 1; bus.unit_done_i = 1; bus.out_ready_i = 1;
    settle();
    chk("fd_no_valid", bus.out_valid_o, 0);
    chk("fd_kill", bus.fsm_kill_o, 1);
    tick();
    bus.flush_i = 0; bus.unit_done_i = 0; bus.out_ready_i = 0;
    settle();
    chk("fd_idle", bus.busy_o, 0);
    chk("fd_valid_off", bus.out_valid_o, 0);
    tick();

    // reset while in HOLD
    accept_op(8'h77, 1'b0);
    repeat (2) tick();
    bus.unit_done_i = 1; bus.out_ready_i = 0;
    tick();
    bus.unit_done_i = 0;
    settle();
    chk("rh_hold_valid", bus.out_valid_o, 1);
    chk("rh_hold_tag", bus.tag_o, 8'h77);
    tick();
    rst = 1;
    settle();
    chk("rh_rst_valid", bus.out_valid_o, 0);
    chk("rh_rst_busy", bus.busy_o, 0);
    tick();
    rst = 0;
    settle();
    chk("rh_after_valid", bus.out_valid_o, 0);
    chk("rh_after_busy", bus.busy_o, 0);
    chk("rh_after_tag", bus.tag_o, 0);
    tick();
    accept_op(8'h88, 1'b1);
    tick();
    bus.unit_done_i = 1; bus.out_ready_i = 1;
    settle();
    chk("rh_new_valid", bus.out_valid_o, 1);
    chk("rh_new_tag", bus.tag_o, 8'h88);
    $display("complete tag=%02h after reset", bus.tag_o);
    tick();
    bus.unit_done_i = 0; bus.out_ready_i = 0;

    // watchdog (TimeoutCycles=4): accept cyc0, kill cyc4
    wbus.in_valid_i = 1; wbus.tag_i = 8'h3C;
    settle();
    chk("wd_start", wbus.fsm_start_o, 1);
    tick();
    wbus.in_valid_i = 0; wbus.tag_i = '0;
    for (int c = 1; c <= 3; c++) begin
      settle();
      chk("wd_no_kill", wbus.fsm_kill_o, 0);
      chk("wd_no_timeout", wbus.timeout_o, 0);
      tick();
    end
    settle();                         // cyc4
    chk("wd_kill", wbus.fsm_kill_o, 1);
    chk("wd_timeout", wbus.timeout_o, 1);
    chk("wd_busy4", wbus.busy_o, 1);
    $display("watchdog kill");
    tick();                           // cyc5
    settle();
    chk("wd_idle", wbus.busy_o, 0);
    chk("wd_timeout_off", wbus.timeout_o, 0);
    tick();

    // watchdog: done on the timeout cycle wins
    wbus.in_valid_i = 1; wbus.tag_i = 8'h4D;
    settle();
    chk("wdd_start", wbus.fsm_start_o, 1);
    tick();
    wbus.in_valid_i = 0; wbus.tag_i = '0;
    repeat (3) tick();                // cyc4
    wbus.unit_done_i = 1; wbus.out_ready_i = 1;
    settle();
    chk("wdd_valid", wbus.out_valid_o, 1);
    chk("wdd_tag", wbus.tag_o, 8'h4D);
    chk("wdd_no_kill", wbus.fsm_kill_o, 0);
    chk("wdd_no_timeout", wbus.timeout_o, 0);
    tick();
    wbus.unit_done_i = 0; wbus.out_ready_i = 0;
    settle();
    chk("wdd_idle", wbus.busy_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
